// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the time-of-day word (hh:mm:ss:cc).
// The VGA digit renderer reuses these definitions.
//   - field limits HH_MAX / MS_MAX / CC_MAX
//   - byte-lane offsets into the 32-bit time word
//   - run/set state encoding; its value doubles as the field select
//   - wrap-around field increment/decrement helpers
package clock_pkg;

  localparam logic [7:0] HH_MAX = 8'd23;
  localparam logic [7:0] MS_MAX = 8'd59;
  localparam logic [7:0] CC_MAX = 8'd99;

  localparam int HH_LSB = 24;
  localparam int MM_LSB = 16;
  localparam int SS_LSB = 8;
  localparam int CC_LSB = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_e;

  // +1 with wrap to 0 past max
  function automatic logic [7:0] fld_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? 8'd0 : v + 8'd1;
  endfunction

  // -1 with wrap from 0 to max
  function automatic logic [7:0] fld_dec(input logic [7:0] v, input logic [7:0] max);
    return (v == 8'd0) ? max : v - 8'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider producing a one-cycle enable every TICK_DIV clocks.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the count at 0 (phase realign)
//   tick : high while the count sits at TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: run/set sequencer for the hh:mm:ss:cc time word.
//   clk, rst                 : 50 MHz clock, synchronous active-high reset
//   key_mode/key_inc/key_dec : debounced one-cycle key pulses
//   data      : time word {hh,mm,ss,cc}, binary bytes (registered)
//   field_sel : 0 run, 1 hh, 2 mm, 3 ss (the state register itself)
//   blink     : show/hide phase of the edited field, 0 in run
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 500_000,
  parameter int BLINK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_dec,
  output logic [31:0] data,
  output logic [1:0]  field_sel,
  output logic        blink
);

  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCW-1:0] BLAST = BCW'(BLINK_DIV - 1);

  state_e          state_q, state_d;
  logic [31:0]     time_q, time_d;
  logic            blink_q, blink_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic            tick, tick_clr;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // One-centisecond advance with carry chain cc -> ss -> mm -> hh.
  function automatic logic [31:0] advance(input logic [31:0] t);
    logic [7:0] hh, mm, ss, cc;
    logic       cc_w, ss_w, mm_w;
    hh = t[HH_LSB +: 8];
    mm = t[MM_LSB +: 8];
    ss = t[SS_LSB +: 8];
    cc = t[CC_LSB +: 8];
    cc_w = (cc == CC_MAX);
    ss_w = cc_w && (ss == MS_MAX);
    mm_w = ss_w && (mm == MS_MAX);
    return {mm_w ? fld_inc(hh, HH_MAX) : hh,
            ss_w ? fld_inc(mm, MS_MAX) : mm,
            cc_w ? fld_inc(ss, MS_MAX) : ss,
            fld_inc(cc, CC_MAX)};
  endfunction

  // inc and dec together cancel out
  function automatic logic [7:0] edit_fld(input logic [7:0] v, input logic [7:0] max,
                                          input logic inc, input logic dec);
    if (inc && !dec) return fld_inc(v, max);
    if (dec && !inc) return fld_dec(v, max);
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    blink_d  = blink_q;
    bcnt_d   = bcnt_q;
    tick_clr = 1'b0;

    // key_mode wins over edits and over the run advance
    case (state_q)
      RUN: begin
        if (key_mode)  state_d = SET_HH;
        else if (tick) time_d  = advance(time_q);
      end
      SET_HH: begin
        if (key_mode) state_d = SET_MM;
        else time_d[HH_LSB +: 8] = edit_fld(time_q[HH_LSB +: 8], HH_MAX, key_inc, key_dec);
      end
      SET_MM: begin
        if (key_mode) state_d = SET_SS;
        else time_d[MM_LSB +: 8] = edit_fld(time_q[MM_LSB +: 8], MS_MAX, key_inc, key_dec);
      end
      SET_SS: begin
        if (key_mode) begin
          // restart the time base so the first advance is a full period away
          state_d              = RUN;
          time_d[CC_LSB +: 8]  = 8'd0;
          tick_clr             = 1'b1;
        end else begin
          time_d[SS_LSB +: 8] = edit_fld(time_q[SS_LSB +: 8], MS_MAX, key_inc, key_dec);
        end
      end
      default: state_d = RUN;
    endcase

    // Blink: visible on field entry, then toggles on global tick boundaries.
    if (state_d == RUN) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (state_d != state_q) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (tick) begin
      if (bcnt_q == BLAST) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      time_q  <= '0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign data      = time_q;
  assign field_sel = state_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_mode = 1'b0;
  logic        key_inc  = 1'b0;
  logic        key_dec  = 1'b0;
  logic [31:0] data;
  logic [1:0]  field_sel;
  logic        blink;

  int n_cmp  = 0;
  int n_err  = 0;
  int edge_n = 0;   // clock edges since last reset release

  clock_set_controller #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .key_dec   (key_dec),
    .data      (data),
    .field_sel (field_sel),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  // advance one edge; inputs change and outputs are sampled 1 ns after it
  task automatic cyc();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic pulse(input logic m, input logic i, input logic d);
    key_mode = m; key_inc = i; key_dec = d;
    cyc();
    key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
  endtask

  initial begin
    logic exp_blink;

    // ---- 1: reset then free run, first advance on the 4th edge
    cyc(); cyc();
    rst = 1'b0;
    edge_n = 0;
    chk("rst_data", data, 32'h0);
    chk("rst_fs", 32'(field_sel), 32'd0);
    chk("rst_blink", 32'(blink), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("pre_tick_data", data, 32'h0);
      chk("pre_tick_fs", 32'(field_sel), 32'd0);
      chk("pre_tick_blink", 32'(blink), 32'd0);
    end
    cyc();                                     // E4
    chk("first_tick", data, 32'h0000_0001);

    // ---- 3: hh edit wrap
    pulse(1'b1, 1'b0, 1'b0);                   // E5 -> SET_HH
    chk("sethh_fs", 32'(field_sel), 32'd1);
    chk("sethh_blink", 32'(blink), 32'd1);
    pulse(1'b0, 1'b0, 1'b1);                   // E6 hh 0 -> 23
    chk("hh_dec_wrap", 32'(data[31:24]), 32'h17);
    chk("hh_dec_fs", 32'(field_sel), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);                   // E7 hh 23 -> 0
    chk("hh_inc_wrap", data, 32'h0000_0001);

    // ---- 5: hold in SET_HH; ticks on E8,E12,...; blink toggles on E12,E20,...
    for (int i = 0; i < 40; i++) begin
      cyc();
      exp_blink = (edge_n < 12) ? 1'b1 : ((((edge_n - 12) / 8) % 2) == 0 ? 1'b0 : 1'b1);
      chk("hold_data", data, 32'h0000_0001);
      chk("hold_blink", 32'(blink), 32'(exp_blink));
    end                                        // ends at E47

    // ---- 4: SET_MM simultaneous keys
    pulse(1'b1, 1'b0, 1'b0);                   // E48 -> SET_MM
    chk("setmm_fs", 32'(field_sel), 32'd2);
    chk("setmm_blink", 32'(blink), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);                   // E49 mm=1
    chk("mm_inc", data, 32'h0001_0001);
    pulse(1'b0, 1'b1, 1'b1);                   // E50 inc+dec
    chk("mm_incdec", data, 32'h0001_0001);
    pulse(1'b1, 1'b1, 1'b0);                   // E51 mode+inc -> SET_SS
    chk("mode_inc_fs", 32'(field_sel), 32'd3);
    chk("mode_inc_data", data, 32'h0001_0001);

    // ---- 2: ss=59, back to RUN, 100 ticks carry cc into ss into mm
    pulse(1'b0, 1'b0, 1'b1);                   // E52 ss 0 -> 59
    chk("ss_dec_wrap", data, 32'h0001_3B01);
    pulse(1'b1, 1'b0, 1'b0);                   // E53 -> RUN, cc=0, tick realign
    chk("run_cc0", data, 32'h0001_3B00);
    chk("run_fs", 32'(field_sel), 32'd0);
    chk("run_blink", 32'(blink), 32'd0);
    cyc(); cyc(); cyc();                       // E56
    chk("realign_hold", data, 32'h0001_3B00);
    cyc();                                     // E57
    chk("realign_first", data, 32'h0001_3B01);
    while (edge_n < 452) cyc();
    chk("cc99", data, 32'h0001_3B63);
    cyc();                                     // E453
    chk("cc_carry", data, 32'h0002_0000);

    // set 23:59:59
    pulse(1'b1, 1'b0, 1'b0);                   // E454 SET_HH
    pulse(1'b0, 1'b0, 1'b1);                   // E455 hh=23
    pulse(1'b1, 1'b0, 1'b0);                   // E456 SET_MM
    chk("set_frozen", data, 32'h1702_0000);    // tick at E457 lands in SET too
    pulse(1'b0, 1'b0, 1'b1);                   // E457 mm=1
    pulse(1'b0, 1'b0, 1'b1);                   // E458 mm=0
    pulse(1'b0, 1'b0, 1'b1);                   // E459 mm=59
    chk("mm_dec_wrap", 32'(data[23:16]), 32'h3B);
    pulse(1'b1, 1'b0, 1'b0);                   // E460 SET_SS
    pulse(1'b0, 1'b0, 1'b1);                   // E461 ss=59
    pulse(1'b1, 1'b0, 1'b0);                   // E462 RUN
    chk("max_time", data, 32'h173B_3B00);
    while (edge_n < 861) cyc();
    chk("day_end_m1", data, 32'h173B_3B63);
    cyc();                                     // E862
    chk("day_wrap", data, 32'h0000_0000);

    // ---- 6: reset mid-edit in SET_MM
    pulse(1'b1, 1'b0, 1'b0);                   // SET_HH
    pulse(1'b1, 1'b0, 1'b0);                   // SET_MM
    for (int i = 0; i < 42; i++) pulse(1'b0, 1'b1, 1'b0);
    chk("mm_2a", 32'(data[23:16]), 32'h2A);
    chk("mm_2a_fs", 32'(field_sel), 32'd2);
    rst = 1'b1;
    cyc();
    chk("midedit_rst_data", data, 32'h0);
    chk("midedit_rst_fs", 32'(field_sel), 32'd0);
    chk("midedit_rst_blink", 32'(blink), 32'd0);
    rst = 1'b0;
    edge_n = 0;
    cyc(); cyc(); cyc();                       // E3
    chk("post_rst_hold", data, 32'h0);
    cyc();                                     // E4
    chk("post_rst_tick", data, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Run/set sequencer for the 32-bit time-of-day word (hh:mm:ss:cc) shown on the VGA clock display. It generates the 10 ms time base as a one-cycle enable in the `clk` domain, so no derived clock is used. In RUN mode it advances the time word. In the three SET modes it freezes the time and lets debounced key pulses edit hours, minutes and seconds. It also outputs the current edit field and a blink flag for the display overlay.

## Interface

Parameters:
- `TICK_DIV`, default 500_000: `clk` cycles per 10 ms tick (50 MHz clock).
- `BLINK_DIV`, default 25: ticks per blink half-period (250 ms).

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: reset, synchronous and active-high.
- `key_mode`  in  1: one-cycle pulse (already debounced); advances the mode.
- `key_inc`  in  1: one-cycle pulse; increments the selected field.
- `key_dec`  in  1: one-cycle pulse; decrements the selected field.
- `data`  out  32: time word. [31:24] hh 0..23, [23:16] mm 0..59, [15:8] ss 0..59, [7:0] cc 0..99. Each byte is plain binary.
- `field_sel`  out  2: 0 = RUN, 1 = hh, 2 = mm, 3 = ss.
- `blink`  out  1: 1 = draw the selected field, 0 = hide it. Always 0 in RUN.

## Operation

- FSM states: RUN → SET_HH → SET_MM → SET_SS → RUN. Each `key_mode` pulse moves one step. `field_sel` equals the state encoding.
- Tick counter `tick_cnt`, width clog2(TICK_DIV):
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` = (`tick_cnt` == TICK_DIV-1).
  - Runs in every state.
- RUN, on `tick`, advances the time by one centisecond:
  - cc 99→0 carries to ss.
  - ss 59→0 carries to mm.
  - mm 59→0 carries to hh.
  - 23:59:59:99 → 00:00:00:00.
  - `key_inc` and `key_dec` are ignored in RUN.
- SET states:
  - The time is frozen and `tick` does not advance it.
  - `key_inc`: selected field +1 with wrap, hh 23→0, mm/ss 59→0. No carry into other fields.
  - `key_dec`: selected field −1 with wrap, 0→23 for hh, 0→59 for mm/ss. No borrow.
- Entering any SET state: `blink`=1 and the blink counter is cleared. After that, `blink` toggles every BLINK_DIV ticks.
- SET_SS → RUN transition:
  - cc is forced to 0.
  - `tick_cnt` is cleared to 0, so the first advance comes a full TICK_DIV cycles later.
- Simultaneous events:
  - `key_inc` and `key_dec` together: no change.
  - `key_mode` together with `key_inc`/`key_dec`: the mode advances and the field is unchanged.
  - `tick` together with `key_mode` in RUN: go to SET_HH, and the time is not advanced that cycle.
- Reset:
  - Outputs: `data`=0, `field_sel`=0, `blink`=0.
  - Internal: state=RUN, `tick_cnt`=0, blink counter=0.
  - Reset has priority over everything and applies in any state, including mid-edit.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Key pulse in cycle N → effect visible on outputs in cycle N+1.
- After reset deasserts, the first RUN increment appears TICK_DIV cycles later. It is registered at the edge that ends the cycle where `tick_cnt`==TICK_DIV-1.
- Steady RUN: exactly one increment every TICK_DIV cycles, with no drift.
- Blink period in SET: 2·BLINK_DIV ticks. Phase is relative to the global tick, not to the state entry.

## Structure

- Shared package `clock_pkg`:
  - Constants `HH_MAX`=23, `MS_MAX`=59, `CC_MAX`=99.
  - Byte-lane offsets for hh/mm/ss/cc.
  - State encoding RUN/SET_HH/SET_MM/SET_SS (2 bits).
  - The package is reused by the VGA digit renderer.
- One sub-module, `tick_gen`:
  - Parameterised divider: `clk`, `rst`, `clr` in; `tick` out.
  - `clr` is driven by the SET_SS → RUN transition.
- Field increment/decrement-with-wrap is a function in `clock_pkg` taking the value and the max.

## Test plan

Bench parameters: TICK_DIV=4, BLINK_DIV=2.

1. Reset, then idle 4 cycles → `data` 0x00000000 until the 4th edge, then 0x00000001. `field_sel`=0 and `blink`=0 throughout.
2. `key_mode`×3 to reach SET_SS, `key_dec` once (ss=59), `key_mode` to RUN, run 100 ticks → cc carries to ss. Separately, set hh=23, mm=59, ss=59 and run 100 ticks → `data` 0x00000000.
3. From RUN: `key_mode`, then `key_dec` → `data`[31:24]=0x17 and `field_sel`=1. Then `key_inc` → 0x00.
4. In SET_MM, assert `key_inc` and `key_dec` together → mm unchanged. Assert `key_mode` and `key_inc` together → `field_sel` becomes 3 and mm unchanged.
5. In SET_HH, hold 40 cycles → `data` constant. `blink` is 1 on entry, then toggles every 8 cycles, phase-locked to the tick.
6. Reset during SET_MM with mm=0x2A → next cycle `data`=0, `field_sel`=0, `blink`=0. The next increment is exactly 4 cycles after reset release.
